key_cond: RTL
=============

# key_cond

Input conditioner for the counting-game board: takes the raw asynchronous push-buttons (btn0, btn7) and DIP switches (sw0–sw7) and delivers synchronized, debounced levels and single-cycle event pulses to `game_top`'s state machine. It is the input-side counterpart of the display/beeper drivers. `game_top` consumes only its outputs and never samples pins directly.

## Interface
Parameters:
- `N_BTN`, 2: number of push-button channels (bit 0 = btn0/sure, bit 1 = btn7/start).
- `N_SW`, 8: number of switch channels (bit 7 = sw7 power/enable).
- `DEB_CYCLES`, 20000: consecutive stable cycles required to accept a level change; ≥2.
- `LONG_CYCLES`, 1000000: debounced-held cycles before a long-press pulse; > `DEB_CYCLES`.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_raw`  in  N_BTN  raw button pins, active-high, asynchronous.
- `sw_raw`  in  N_SW  raw switch pins, asynchronous.
- `btn_level`  out  N_BTN  debounced button level.
- `btn_press`  out  N_BTN  1-cycle pulse on accepted 0→1.
- `btn_release`  out  N_BTN  1-cycle pulse on accepted 1→0.
- `btn_long`  out  N_BTN  1-cycle pulse once per hold, after `LONG_CYCLES` held.
- `sw_level`  out  N_SW  debounced switch level.
- `sw_change`  out  N_SW  1-cycle pulse on any accepted switch transition.

## Operation
- Every raw bit passes a 2-flop synchronizer; output `s` is the only value the logic observes.
- Per channel, a 4-state FSM with a counter `cnt` (width clog2(DEB_CYCLES)):
  - IDLE (level 0): `s`=1 → DOWN_CNT, cnt=1.
  - DOWN_CNT: `s`=0 → IDLE, cnt=0, no pulse. `s`=1 and cnt=DEB_CYCLES-1 → HELD, level←1, press pulse. Otherwise cnt++.
  - HELD (level 1): `s`=0 → UP_CNT, cnt=1.
  - UP_CNT: `s`=1 → HELD, cnt=0, no pulse, hold counter keeps running. `s`=0 and cnt=DEB_CYCLES-1 → IDLE, level←0, release pulse. Otherwise cnt++.
- Long-press (buttons only): `hold` counter (width clog2(LONG_CYCLES+1)) clears on entry to HELD. It increments while in HELD or UP_CNT. It saturates at LONG_CYCLES. `btn_long` pulses exactly on the cycle it reaches LONG_CYCLES. At most one long pulse per press. Clears on entry to IDLE.
- Switch channels use the same FSM with no hold counter. `sw_change` = press | release.
- Channels are fully independent. Simultaneous events on several channels each pulse in the same cycle.
- Reset: FSMs → IDLE, all counters and synchronizer flops 0. All outputs 0, including `sw_level`, even when a switch is physically on. The switch is re-accepted DEB_CYCLES+2 cycles after reset releases, with a `sw_change` pulse. Reset mid-debounce or mid-hold discards the progress; no pulse is emitted.

## Timing
- All outputs are registered.
- A raw edge sampled at cycle 0 that stays stable appears in `s` at cycle 2. Level and pulse assert at cycle DEB_CYCLES+2.
- Release latency is identical.
- Long pulse: cycle DEB_CYCLES+2+LONG_CYCLES after the raw edge, provided the button is still held.
- A glitch shorter than DEB_CYCLES cycles (post-sync) produces no output change.
- Pulses are exactly 1 cycle wide. Press and release on the same channel are at least DEB_CYCLES cycles apart.

## Structure
- Shared include `game_defs.vh`: FSM state encodings (IDLE=0, DOWN_CNT=1, HELD=2, UP_CNT=3), default DEB_CYCLES/LONG_CYCLES, board bit indices (BTN_SURE=0, BTN_START=1, SW_EN=7). `game_top` uses the same file.
- Sub-module `debounce_ch`: one channel containing synchronizer, FSM and optional hold counter, with parameter `HAS_LONG`. `key_cond` instantiates it N_BTN times with HAS_LONG=1 and N_SW times with HAS_LONG=0 via generate loops.

## Test plan
Run with DEB_CYCLES=4, LONG_CYCLES=10.
- Reset: hold `rst` 3 cycles with sw_raw=8'h80 → all outputs 0 during reset. `sw_level[7]` and `sw_change[7]` rise at cycle 6 after release; `sw_change` falls at cycle 7.
- Clean press: btn_raw[0] 0→1 at cycle 0 and held → `btn_press[0]`=1 only at cycle 6, `btn_level[0]`=1 from cycle 6, `btn_level[1]` stays 0.
- Bounce: btn_raw[1] toggles 1,0,1,1,0 over cycles 0–4 then stays 0 → no press, release or level change.
- Long press: btn_raw[0] held 20 cycles → press at 6, `btn_long[0]` single pulse at 16. Release at cycle 20 gives `btn_release[0]` at 26.
- Release glitch: HELD button drops low for 3 cycles → level stays 1, no release pulse, long pulse still at the original cycle.
- Simultaneous: btn_raw=2'b11 and sw_raw[3] rise at the same cycle → both presses and `sw_change[3]` pulse together at cycle 6.

Source files
------------

// File: rtl/key_cond_pkg.sv
// key_cond_pkg
//   Shared definitions for the counting-game input conditioner and its
//   consumer (game_top): per-channel debounce FSM state encoding, default
//   timing constants and the board bit positions of the buttons/switches.
package key_cond_pkg;

  // Debounce channel states. The encoding is fixed because game_top decodes
  // the same values.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DOWN_CNT = 2'd1,
    ST_HELD     = 2'd2,
    ST_UP_CNT   = 2'd3
  } key_st_e;

  // Default timing, in clk cycles.
  localparam int unsigned DEF_DEB_CYCLES  = 20000;
  localparam int unsigned DEF_LONG_CYCLES = 1000000;

  // Board bit indices.
  localparam int unsigned BTN_SURE  = 0;
  localparam int unsigned BTN_START = 1;
  localparam int unsigned SW_EN     = 7;

endpackage

// File: rtl/key_cond_debounce_ch.sv
// key_cond_debounce_ch
//   One input channel: 2-flop synchronizer, 4-state debounce FSM and an
//   optional long-press hold counter (HAS_LONG).
//
//   state       | meaning
//   ------------+-----------------------------------------------
//   ST_IDLE     | accepted level 0, input stable low
//   ST_DOWN_CNT | level 0, input high, counting toward accept
//   ST_HELD     | accepted level 1, input stable high
//   ST_UP_CNT   | level 1, input low, counting toward accept
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   raw          in   asynchronous raw pin
//   level        out  debounced level
//   press_pulse  out  1-cycle pulse on accepted 0->1
//   rel_pulse    out  1-cycle pulse on accepted 1->0
//   long_pulse   out  1-cycle pulse once per hold after LONG_CYCLES
//   change_pulse out  press_pulse | rel_pulse
module key_cond_debounce_ch
  import key_cond_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES,
  parameter bit          HAS_LONG    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic rel_pulse,
  output logic long_pulse,
  output logic change_pulse
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, s_q;
  key_st_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             change_q, change_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_q) begin
          state_d = ST_DOWN_CNT;
          cnt_d   = CNT_ONE;
        end
      end
      ST_DOWN_CNT: begin
        if (!s_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!s_q) begin
          state_d = ST_UP_CNT;
          cnt_d   = CNT_ONE;
        end
      end
      ST_UP_CNT: begin
        if (s_q) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
    change_d = press_d | rel_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      s_q      <= 1'b0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      change_q <= 1'b0;
    end else begin
      sync1_q  <= raw;
      s_q      <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      change_q <= change_d;
    end
  end

  assign level        = level_q;
  assign press_pulse  = press_q;
  assign rel_pulse    = rel_q;
  assign change_pulse = change_q;

  if (HAS_LONG) begin : g_long
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;

    // Only a fresh press restarts the hold count; returning to HELD after a
    // rejected release glitch keeps counting, so the long pulse is not delayed.
    always_comb begin
      hold_d = hold_q;
      long_d = 1'b0;
      if (press_d || state_d == ST_IDLE) begin
        hold_d = '0;
      end else if ((state_q == ST_HELD || state_q == ST_UP_CNT) &&
                   hold_q != HOLD_MAX) begin
        hold_d = hold_q + HOLD_ONE;
        long_d = (hold_d == HOLD_MAX);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        hold_q <= '0;
        long_q <= 1'b0;
      end else begin
        hold_q <= hold_d;
        long_q <= long_d;
      end
    end

    assign long_pulse = long_q;
  end else begin : g_no_long
    assign long_pulse = 1'b0;
  end

endmodule

// File: rtl/key_cond.sv
// key_cond
//   Input conditioner for the counting-game board. Synchronizes and debounces
//   the raw push-buttons and DIP switches and produces levels and 1-cycle
//   event pulses for game_top. Every channel is independent.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   btn_raw      in   raw buttons (bit 0 = sure, bit 1 = start)
//   sw_raw       in   raw switches (bit 7 = power/enable)
//   btn_level    out  debounced button levels
//   btn_press    out  1-cycle pulse on accepted press
//   btn_release  out  1-cycle pulse on accepted release
//   btn_long     out  1-cycle pulse once per hold after LONG_CYCLES
//   sw_level     out  debounced switch levels
//   sw_change    out  1-cycle pulse on any accepted switch transition
module key_cond
  import key_cond_pkg::*;
#(
  parameter int unsigned N_BTN       = 2,
  parameter int unsigned N_SW        = 8,
  parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_SW-1:0]  sw_level,
  output logic [N_SW-1:0]  sw_change
);

  // Channel outputs that this top does not forward.
  logic [N_BTN-1:0] btn_change_unused;
  logic [N_SW-1:0]  sw_press_unused;
  logic [N_SW-1:0]  sw_rel_unused;
  logic [N_SW-1:0]  sw_long_unused;

  for (genvar i = 0; i < int'(N_BTN); i++) begin : g_btn
    key_cond_debounce_ch #(
      .DEB_CYCLES  (DEB_CYCLES),
      .LONG_CYCLES (LONG_CYCLES),
      .HAS_LONG    (1'b1)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .raw          (btn_raw[i]),
      .level        (btn_level[i]),
      .press_pulse  (btn_press[i]),
      .rel_pulse    (btn_release[i]),
      .long_pulse   (btn_long[i]),
      .change_pulse (btn_change_unused[i])
    );
  end

  for (genvar i = 0; i < int'(N_SW); i++) begin : g_sw
    key_cond_debounce_ch #(
      .DEB_CYCLES  (DEB_CYCLES),
      .LONG_CYCLES (LONG_CYCLES),
      .HAS_LONG    (1'b0)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .raw          (sw_raw[i]),
      .level        (sw_level[i]),
      .press_pulse  (sw_press_unused[i]),
      .rel_pulse    (sw_rel_unused[i]),
      .long_pulse   (sw_long_unused[i]),
      .change_pulse (sw_change[i])
    );
  end

endmodule
